// File: rtl/square_motion_engine_if.sv
// Control and position bus between the VGA-side controller and the square motion engine.
// The controller drives the frame tick and pause; the engine returns positions and status.
interface square_motion_engine_if;
    logic         refresh_tick;
    logic         pause;
    logic [659:0] position;
    logic         busy;
    logic         update_done;
    logic         overrun;

    modport master (
        output refresh_tick, pause,
        input  position, busy, update_done, overrun
    );

    modport slave (
        input  refresh_tick, pause,
        output position, busy, update_done, overrun
    );
endinterface

// File: rtl/square_motion_engine.sv
// Moves 16 bouncing squares once per frame: serial update into a shadow copy,
// then a single-cycle atomic publish so the pixel generator never sees a torn frame.
module square_motion_engine #(
    parameter int NUM_SQUARES = 16,
    parameter int SQUARE_SIZE = 10,
    parameter int STEP        = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    square_motion_engine_if.slave bus
);
    localparam int          IDX_W  = $clog2(NUM_SQUARES);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SQUARE_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - SQUARE_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] UPDATE = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overrun;
    logic [9:0]             r_x  [NUM_SQUARES];
    logic [9:0]             r_y  [NUM_SQUARES];
    logic [9:0]             r_sx [NUM_SQUARES];
    logic [9:0]             r_sy [NUM_SQUARES];
    logic [NUM_SQUARES-1:0] r_dx;
    logic [NUM_SQUARES-1:0] r_dy;

    axis_t                  w_nx;
    axis_t                  w_ny;
    logic [659:0]           w_position;

    // Sums are widened to 11 bits so x + STEP near the right edge cannot wrap.
    function automatic axis_t step_axis(input logic [9:0] cur, input logic dir,
                                        input logic [10:0] lim);
        axis_t r;
        if (dir) begin
            if ({1'b0, cur} + STEP_W > lim) begin
                r.pos = lim[9:0];
                r.dir = 1'b0;
            end else begin
                r.pos = 10'({1'b0, cur} + STEP_W);
                r.dir = 1'b1;
            end
        end else begin
            if ({1'b0, cur} < STEP_W) begin
                r.pos = '0;
                r.dir = 1'b1;
            end else begin
                r.pos = 10'({1'b0, cur} - STEP_W);
                r.dir = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        w_nx = step_axis(r_sx[r_idx], r_dx[r_idx], X_MAX);
        w_ny = step_axis(r_sy[r_idx], r_dy[r_idx], Y_MAX);
    end

    // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_position = '0;
        for (int i = 0; i < NUM_SQUARES; i++) begin
            w_position[i*40 +: 10]    = r_x[i];
            w_position[i*40+10 +: 10] = r_y[i];
        end
    end

    // NOTE: the position arrays sit in the async reset because the display needs a known layout immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_SQUARES; i++) begin
                r_x[i]  <= 10'(16 + 38 * i);
                r_y[i]  <= 10'(16 + 28 * i);
                r_sx[i] <= 10'(16 + 38 * i);
                r_sy[i] <= 10'(16 + 28 * i);
                r_dx[i] <= i[0];
                r_dy[i] <= i[1];
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_done <= 1'b0;
            if (bus.refresh_tick && !bus.pause && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.refresh_tick && !bus.pause) begin
                        r_state <= UPDATE;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                UPDATE: begin
                    r_sx[r_idx] <= w_nx.pos;
                    r_dx[r_idx] <= w_nx.dir;
                    r_sy[r_idx] <= w_ny.pos;
                    r_dy[r_idx] <= w_ny.dir;
                    r_idx       <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(NUM_SQUARES - 1)) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_x     <= r_sx;
                    r_y     <= r_sy;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.position    = w_position;
    assign bus.busy        = r_busy;
    assign bus.update_done = r_done;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_square_motion_engine.sv
// Scoreboard bench for square_motion_engine: each issued tick queues hand-derived
// positions for slots 0, 1 and 15; a monitor checks them when update_done fires.
module tb_square_motion_engine;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    square_motion_engine_if sif ();

    square_motion_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    typedef struct {
        int         k;
        logic [9:0] x0, y0, x1, y1, x15, y15;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           n_done = 0;
    logic [659:0] prev_pos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] slot_x(input logic [659:0] p, input int i);
        return p[i*40 +: 10];
    endfunction

    function automatic logic [9:0] slot_y(input logic [659:0] p, input int i);
        return p[i*40+10 +: 10];
    endfunction

    function automatic logic spare_set(input logic [659:0] p);
        logic [659:0] m;
        m = p;
        for (int i = 0; i < 16; i++) m[i*40 +: 20] = '0;
        return |m;
    endfunction

    // Hand-derived trajectories after k frames (STEP = 2, walls at 0 / 630 / 470).
    function automatic exp_t make_exp(input int k);
        exp_t e;
        e.k   = k;
        e.x0  = 10'((k <= 8)  ? 16 - 2*k  : 2*(k - 9));
        e.y0  = e.x0;
        e.x1  = 10'(54 + 2*k);
        e.y1  = 10'((k <= 22) ? 44 - 2*k  : 2*(k - 23));
        e.x15 = 10'((k <= 22) ? 586 + 2*k : 630 - 2*(k - 23));
        e.y15 = 10'((k <= 17) ? 436 + 2*k : 470 - 2*(k - 18));
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_pos = sif.position;
        end else begin
            if (sif.position !== prev_pos) check("pos_change_only_at_commit", sif.update_done, 1);
            if (sif.update_done) begin
                n_done++;
                check("update_was_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("k%0d_slot0_x", e.k),  slot_x(sif.position, 0),  e.x0);
                    check($sformatf("k%0d_slot0_y", e.k),  slot_y(sif.position, 0),  e.y0);
                    check($sformatf("k%0d_slot1_x", e.k),  slot_x(sif.position, 1),  e.x1);
                    check($sformatf("k%0d_slot1_y", e.k),  slot_y(sif.position, 1),  e.y1);
                    check($sformatf("k%0d_slot15_x", e.k), slot_x(sif.position, 15), e.x15);
                    check($sformatf("k%0d_slot15_y", e.k), slot_y(sif.position, 15), e.y15);
                    check($sformatf("k%0d_spare_bits", e.k), spare_set(sif.position), 0);
                end
            end
            prev_pos = sif.position;
        end
    end

    // Called on a negative edge; issues one tick and follows the busy window.
    task automatic do_tick(input bit expect_update, input int k);
        logic [659:0] snap;
        int           n;
        bit           stable;
        snap = sif.position;
        if (expect_update) sb_q.push_back(make_exp(k));
        sif.refresh_tick = 1'b1;
        @(negedge clk);
        sif.refresh_tick = 1'b0;
        n      = 0;
        stable = 1'b1;
        while (sif.busy && n < 40) begin
            n++;
            if (sif.position !== snap) stable = 1'b0;
            @(negedge clk);
        end
        check($sformatf("k%0d_busy_cycles", k), n, 17);
        check($sformatf("k%0d_pos_stable_while_busy", k), stable, 1);
        check($sformatf("k%0d_done_at_busy_fall", k), sif.update_done, 1);
        @(negedge clk);
        check($sformatf("k%0d_done_one_cycle", k), sif.update_done, 0);
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int           n;
        int           base;
        bit           busy_seen;
        logic [659:0] snap;

        sif.refresh_tick = 1'b0;
        sif.pause        = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_slot0_x",  slot_x(sif.position, 0),  16);
        check("rst_slot0_y",  slot_y(sif.position, 0),  16);
        check("rst_slot1_x",  slot_x(sif.position, 1),  54);
        check("rst_slot1_y",  slot_y(sif.position, 1),  44);
        check("rst_slot15_x", slot_x(sif.position, 15), 586);
        check("rst_slot15_y", slot_y(sif.position, 15), 436);
        check("rst_spare_bits", spare_set(sif.position), 0);
        check("rst_busy",     sif.busy,        0);
        check("rst_done",     sif.update_done, 0);
        check("rst_overrun",  sif.overrun,     0);

        // Free running through both wall bounces of slots 0, 1 and 15.
        for (int k = 1; k <= 24; k++) begin
            do_tick(1'b1, k);
            if (k == 1) begin
                check("k1_slot3_x", slot_x(sif.position, 3), 132);
                check("k1_slot3_y", slot_y(sif.position, 3), 102);
            end
            repeat (2) @(negedge clk);
        end
        check("no_overrun_spaced_ticks", sif.overrun, 0);

        // Second tick while busy is dropped and flags overrun.
        apply_reset();
        base = n_done;
        sb_q.push_back(make_exp(1));
        sif.refresh_tick = 1'b1;
        @(negedge clk);
        sif.refresh_tick = 1'b0;
        repeat (4) @(negedge clk);
        sif.refresh_tick = 1'b1;
        @(negedge clk);
        sif.refresh_tick = 1'b0;
        n = 0;
        while (sif.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_tick_update_finished", sif.busy, 0);
        repeat (30) @(negedge clk);
        check("busy_tick_single_update", n_done - base, 1);
        check("overrun_set", sif.overrun, 1);

        // Paused tick: nothing starts, overrun keeps its value.
        snap      = sif.position;
        sif.pause = 1'b1;
        sif.refresh_tick = 1'b1;
        @(negedge clk);
        sif.refresh_tick = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            if (sif.busy) busy_seen = 1'b1;
            @(negedge clk);
        end
        check("pause_no_busy", busy_seen, 0);
        check("pause_pos_unchanged", sif.position == snap, 1);
        check("pause_overrun_sticky", sif.overrun, 1);
        sif.pause = 1'b0;

        // Reset in the middle of an update aborts it.
        apply_reset();
        check("post_reset_overrun_clear", sif.overrun, 0);
        base = n_done;
        sif.refresh_tick = 1'b1;
        @(negedge clk);
        sif.refresh_tick = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_update_busy", sif.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_slot0_x",  slot_x(sif.position, 0),  16);
        check("mid_rst_slot0_y",  slot_y(sif.position, 0),  16);
        check("mid_rst_slot15_x", slot_x(sif.position, 15), 586);
        check("mid_rst_busy",     sif.busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("aborted_update_not_published", n_done - base, 0);
        do_tick(1'b1, 1);
        repeat (2) @(negedge clk);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end
endmodule
